// File: rtl/rfifo_pix_unpack_pkg.sv
// Shared widths, raster defaults and FSM encoding for the pixel unpacker.
// Imported by the interface, the word buffer and the top.
package rfifo_pix_unpack_pkg;
  localparam int PIX_DW  = 16;
  localparam int FIFO_DW = 2 * PIX_DW;

  localparam int H_ACTIVE_720P = 1280;
  localparam int V_ACTIVE_720P = 720;

  typedef logic [FIFO_DW-1:0] word_t;
  typedef logic [PIX_DW-1:0]  pix_t;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;
endpackage

// File: rtl/rfifo_pix_unpack_if.sv
// FIFO read side and pixel stream of the unpacker.
// master: unpacker side; slave: FIFO + pixel sink side.
interface rfifo_pix_unpack_if;
  import rfifo_pix_unpack_pkg::*;

  logic  fifo_rd_en;
  word_t fifo_rd_data;
  logic  fifo_rd_empty;
  logic  pix_valid;
  logic  pix_ready;
  pix_t  pix_data;
  logic  pix_sof;
  logic  pix_eol;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_sof,
    output pix_eol
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_sof,
    input  pix_eol
  );
endinterface

// File: rtl/rfifo_word_skid.sv
// 2-entry word buffer with in-flight tracking and read enable.
// Ports: FIFO read side, pop/flush from top, head word, occupancy.
module rfifo_word_skid
  import rfifo_pix_unpack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       pop,
  input  logic       fifo_rd_empty,
  input  word_t      fifo_rd_data,
  output logic       fifo_rd_en,
  output word_t      head,
  output logic [1:0] occ
);
  word_t      mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       inflight;
  logic       run;
  logic [1:0] cnt;
  logic [1:0] pend;
  logic       push;

  // a pop this cycle is not credited, so cnt+inflight never exceeds 2
  assign pend = cnt + {1'b0, inflight};

  // run keeps the read enable low through and just after reset;
  // no read is issued in a flush cycle so nothing is left in flight
  assign fifo_rd_en = run && !flush
                   && !fifo_rd_empty
                   && (pend < 2'd2);

  assign push = inflight && !flush;
  assign head = mem[rd_ptr];
  assign occ  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        cnt    <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= fifo_rd_data;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push}
                   - {1'b0, pop};
      end
    end
  end
endmodule

// File: rtl/rfifo_pix_unpack.sv
// Unpacks 32-bit FIFO words into RGB565 pixels over a fixed raster.
// Ports: clk, rst_n, bus (FIFO + pixel stream), frame_start, underflow, frame_abort.
module rfifo_pix_unpack
  import rfifo_pix_unpack_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_720P,
  parameter int V_ACTIVE  = V_ACTIVE_720P,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  rfifo_pix_unpack_if.master bus,
  input  logic              frame_start,
  output logic              underflow,
  output logic              frame_abort
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t        state;
  logic          half;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  word_t         head;
  logic [1:0]    occ;
  logic          is_act;
  logic          avail;
  logic          last_x;
  logic          last_y;
  logic          fin_cand;
  logic          abort;
  logic          hs;
  logic          pop;
  logic          hi_sel;

  assign is_act = (state == ACTIVE);
  assign avail  = is_act && (occ != 2'd0);
  assign last_x = (x == X_LAST);
  assign last_y = (y == Y_LAST);

  // frame_start on the final handshake starts a new frame, not an abort
  assign fin_cand = avail && bus.pix_ready
                 && last_x && last_y;
  assign abort = is_act && frame_start
              && !fin_cand;

  assign bus.pix_valid = avail && !abort;
  assign hs  = bus.pix_valid && bus.pix_ready;
  assign pop = hs && half;

  assign hi_sel = LOW_FIRST ? half : !half;

  assign bus.pix_data = !bus.pix_valid ? '0
                      : hi_sel ? head[FIFO_DW-1:PIX_DW]
                      : head[PIX_DW-1:0];

  assign bus.pix_sof = bus.pix_valid
                    && (x == '0) && (y == '0);
  assign bus.pix_eol = bus.pix_valid && last_x;

  assign underflow = is_act && bus.pix_ready
                  && (occ == 2'd0) && !abort;
  assign frame_abort = abort;

  rfifo_word_skid u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (abort),
    .pop           (pop),
    .fifo_rd_empty (bus.fifo_rd_empty),
    .fifo_rd_data  (bus.fifo_rd_data),
    .fifo_rd_en    (bus.fifo_rd_en),
    .head          (head),
    .occ           (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      half  <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      if (abort) begin
        half <= 1'b0;
        x    <= '0;
        y    <= '0;
      end else if (hs) begin
        half <= ~half;
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      if (!is_act) begin
        if (frame_start)
          state <= ACTIVE;
      end else if (hs && last_x && last_y) begin
        state <= frame_start ? ACTIVE : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rfifo_pix_unpack.sv
// Scoreboard bench for rfifo_pix_unpack on a 4x2 raster.
// FIFO model feeds words; a monitor checks pixels against a queue.
module tb_rfifo_pix_unpack;
  import rfifo_pix_unpack_pkg::*;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int SZ   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs = 1'b0;
  logic fs2 = 1'b0;
  logic uf, ab, uf2, ab2;

  always #5 clk = ~clk;

  rfifo_pix_unpack_if bus ();
  rfifo_pix_unpack_if bus2 ();

  rfifo_pix_unpack #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LOW_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .frame_start(fs), .underflow(uf),
    .frame_abort(ab)
  );

  rfifo_pix_unpack #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LOW_FIRST(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .frame_start(fs2), .underflow(uf2),
    .frame_abort(ab2)
  );

  int checks = 0;
  int errors = 0;

  // source words: written by stimulus, read by the FIFO model
  logic [31:0] wbuf [SZ];
  int wr_cnt = 0;
  int wr_rd = 0;
  // expected pixels: pushed on each accepted read, popped by monitor
  logic [15:0] pbuf [SZ];
  int ep_wr = 0;
  int ep_rd = 0;

  bit active = 1'b0;
  int pos = 0;
  int n_hs = 0;
  int n_abort = 0;
  int n_uf = 0;
  int run = 0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, req);
    end
  endtask

  // read FIFO: latency 1, data held between reads
  initial begin
    logic [31:0] w;
    bus.fifo_rd_empty = 1'b1;
    bus.fifo_rd_data = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        wr_rd = wr_cnt;
      end else if (bus.fifo_rd_en && wr_rd != wr_cnt) begin
        w = wbuf[wr_rd % SZ];
        wr_rd++;
        bus.fifo_rd_data <= w;
        pbuf[ep_wr % SZ] = w[15:0];
        pbuf[(ep_wr + 1) % SZ] = w[31:16];
        ep_wr += 2;
      end
      bus.fifo_rd_empty <= (wr_rd == wr_cnt);
    end
  end

  // single-word source for the high-half-first instance
  initial begin
    bit got2;
    got2 = 1'b0;
    bus2.fifo_rd_empty = 1'b1;
    bus2.fifo_rd_data = '0;
    forever begin
      @(posedge clk);
      if (rst_n && bus2.fifo_rd_en) begin
        got2 = 1'b1;
        bus2.fifo_rd_data <= 32'hBBBB_AAAA;
      end
      bus2.fifo_rd_empty <= got2 || !rst_n;
    end
  end

  // monitor + frame model
  initial begin
    bit v, r, hs, last, ab_exp, act0, prev_stall;
    logic [15:0] prev_data, e;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ep_rd = ep_wr;
        active = 1'b0;
        pos = 0;
        prev_stall = 1'b0;
        run = 0;
      end else begin
        v = bus.pix_valid;
        r = bus.pix_ready;
        hs = v && r;
        act0 = active;
        last = (pos == NPIX - 1);
        ab_exp = act0 && fs && !(hs && last);
        chk(ab == ab_exp, "frame_abort",
            int'(ab), int'(ab_exp));
        chk(uf == (act0 && r && !v && !ab_exp),
            "underflow", int'(uf),
            int'(act0 && r && !v && !ab_exp));
        chk(!(bus.fifo_rd_en && bus.fifo_rd_empty),
            "rd_en_while_empty",
            int'(bus.fifo_rd_en), 0);
        chk(!(v && !act0), "valid_when_idle",
            int'(v), 0);
        chk(v || !(bus.pix_sof || bus.pix_eol),
            "marker_without_valid",
            int'({bus.pix_sof, bus.pix_eol}), 0);
        if (ab_exp)
          chk(!v, "valid_in_abort", int'(v), 0);
        if (prev_stall && !ab_exp) begin
          chk(v, "stall_valid_drop", int'(v), 1);
          chk(bus.pix_data == prev_data, "stall_data",
              int'(bus.pix_data), int'(prev_data));
        end
        if (hs) begin
          chk(ep_rd != ep_wr, "extra_pixel",
              int'(bus.pix_data), 0);
          if (ep_rd != ep_wr) begin
            e = pbuf[ep_rd % SZ];
            ep_rd++;
            chk(bus.pix_data == e, "pix_data",
                int'(bus.pix_data), int'(e));
            chk(bus.pix_sof == (pos == 0), "pix_sof",
                int'(bus.pix_sof), int'(pos == 0));
            chk(bus.pix_eol == ((pos % H) == H - 1),
                "pix_eol", int'(bus.pix_eol),
                int'((pos % H) == H - 1));
          end
          n_hs++;
          run++;
        end else begin
          run = 0;
        end
        if (uf) n_uf++;
        if (ab_exp) begin
          ep_rd = ep_wr;
          pos = 0;
          n_abort++;
        end else if (hs) begin
          if (last) begin
            pos = 0;
            active = fs;
          end else begin
            pos++;
          end
        end
        if (!act0 && fs) active = 1'b1;
        prev_stall = v && !r;
        prev_data = bus.pix_data;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    wbuf[wr_cnt % SZ] = w;
    wr_cnt++;
  endtask

  task automatic push4();
    push(32'h2222_1111);
    push(32'h4444_3333);
    push(32'h6666_5555);
    push(32'h8888_7777);
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    cyc(1);
    fs = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (active && t < 2000) begin
      if (wr_cnt - wr_rd < 4) push($urandom);
      cyc(1);
      t++;
    end
    chk(!active, {"timeout_", nm}, t, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk(bus.fifo_rd_en == 0, {nm, "_rd_en"},
        int'(bus.fifo_rd_en), 0);
    chk(bus.pix_valid == 0, {nm, "_valid"},
        int'(bus.pix_valid), 0);
    chk(bus.pix_data == 0, {nm, "_data"},
        int'(bus.pix_data), 0);
    chk(bus.pix_sof == 0, {nm, "_sof"},
        int'(bus.pix_sof), 0);
    chk(bus.pix_eol == 0, {nm, "_eol"},
        int'(bus.pix_eol), 0);
    chk(uf == 0, {nm, "_underflow"}, int'(uf), 0);
    chk(ab == 0, {nm, "_abort"}, int'(ab), 0);
  endtask

  initial begin
    int mr, t, base, got;
    logic [15:0] p [2];
    logic s0, e0;
    bus.pix_ready = 1'b0;
    bus2.pix_ready = 1'b0;

    cyc(2);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(6);

    // high half first
    bus2.pix_ready = 1'b1;
    fs2 = 1'b1;
    cyc(1);
    fs2 = 1'b0;
    got = 0;
    t = 0;
    s0 = 1'b0;
    e0 = 1'b0;
    while (got < 2 && t < 20) begin
      @(negedge clk);
      if (bus2.pix_valid && bus2.pix_ready) begin
        if (got == 0) begin
          s0 = bus2.pix_sof;
          e0 = bus2.pix_eol;
        end
        p[got] = bus2.pix_data;
        got++;
      end
      t++;
    end
    chk(got == 2, "lf0_count", got, 2);
    chk(p[0] == 16'hBBBB, "lf0_first",
        int'(p[0]), 32'hBBBB);
    chk(p[1] == 16'hAAAA, "lf0_second",
        int'(p[1]), 32'hAAAA);
    chk(s0 == 1'b1, "lf0_sof", int'(s0), 1);
    chk(e0 == 1'b0, "lf0_eol", int'(e0), 0);
    @(negedge clk);
    chk(uf2 == 1'b1, "lf0_underflow", int'(uf2), 1);
    chk(ab2 == 1'b0, "lf0_abort", int'(ab2), 0);
    cyc(1);
    bus2.pix_ready = 1'b0;

    // full-rate frame
    push4();
    cyc(4);
    bus.pix_ready = 1'b1;
    base = n_hs;
    pulse_fs();
    mr = 0;
    t = 0;
    do begin
      cyc(1);
      if (run > mr) mr = run;
      t++;
    end while (active && t < 100);
    chk(mr == NPIX, "burst_len", mr, NPIX);
    chk(n_hs - base == NPIX, "frame1_pixels",
        n_hs - base, NPIX);
    chk(!active, "frame1_idle", int'(active), 0);
    cyc(3);

    // ready toggling every cycle
    push4();
    cyc(4);
    bus.pix_ready = 1'b0;
    pulse_fs();
    t = 0;
    while (active && t < 100) begin
      bus.pix_ready = !bus.pix_ready;
      cyc(1);
      t++;
    end
    chk(!active, "timeout_toggle", t, 0);
    bus.pix_ready = 1'b1;
    cyc(3);

    // starvation mid-frame
    push(32'h2222_1111);
    push(32'h4444_3333);
    cyc(4);
    base = n_uf;
    pulse_fs();
    cyc(10);
    chk(n_uf - base >= 4, "underflow_pulses",
        n_uf - base, 4);
    push(32'h6666_5555);
    push(32'h8888_7777);
    wait_idle("starve");
    cyc(3);

    // abort after three pixels
    push4();
    cyc(4);
    base = n_hs;
    pulse_fs();
    t = 0;
    while (n_hs - base < 3 && t < 50) begin
      cyc(1);
      t++;
    end
    chk(n_hs - base == 3, "pre_abort_pixels",
        n_hs - base, 3);
    base = n_abort;
    pulse_fs();
    chk(n_abort - base == 1, "abort_count",
        n_abort - base, 1);
    push(32'hDDDD_CCCC);
    push(32'hFFFF_EEEE);
    wait_idle("abort");
    cyc(3);

    // reset mid-line
    push4();
    cyc(4);
    pulse_fs();
    cyc(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push4();
    base = n_hs;
    cyc(10);
    chk(n_hs == base, "pixels_before_fs",
        n_hs - base, 0);
    pulse_fs();
    wait_idle("after_reset");

    // randomized traffic with occasional aborts
    for (int i = 0; i < 600; i++) begin
      bus.pix_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0
          && wr_cnt - wr_rd < 16)
        push($urandom);
      fs = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    fs = 1'b0;
    bus.pix_ready = 1'b1;
    wait_idle("random");
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
